process_ready_table: RTL and testbench

PROCESS_READY_TABLE -- requirements
Module: process_ready_table

---
 rtl/process_pkg.sv | 17 +
 rtl/context_slot.sv | 33 +++
 rtl/process_ready_table.sv | 158 +++++++++++++++
 tb/tb_process_ready_table.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/process_pkg.sv
// Shared encodings for the process ready table: per-slot lifecycle states
// and the scheduler search FSM states.
package process_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'b00,
    SLOT_READY   = 2'b01,
    SLOT_RUNNING = 2'b10
  } slot_state_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_REPORT = 2'b10
  } fsm_state_t;

endpackage

// File: rtl/context_slot.sv
// One process context: lifecycle state plus saved program counter.
// The strobes are mutually exclusive by construction in the parent.
module context_slot
  import process_pkg::*;
#(
  parameter int PCW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            create,
  input  logic            save,
  input  logic            finish,
  input  logic            select,
  input  logic [PCW-1:0]  pc_in,
  output slot_state_t     state,
  output logic [PCW-1:0]  pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SLOT_FREE;
      pc    <= '0;
    end else if (finish) begin
      state <= SLOT_FREE;
    end else if (create || save) begin
      state <= SLOT_READY;
      pc    <= pc_in;
    end else if (select) begin
      state <= SLOT_RUNNING;
    end
  end

endmodule

// File: rtl/process_ready_table.sv
// Process table with prioritised create/save/finish commands and a
// one-slot-per-cycle round-robin search for the next READY process.
module process_ready_table
  import process_pkg::*;
#(
  parameter int NPROC = 8,
  parameter int PCW   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     create_req,
  input  logic                     save_req,
  input  logic                     finish_req,
  input  logic                     sched_req,
  input  logic [$clog2(NPROC)-1:0] proc_id,
  input  logic [PCW-1:0]           pc_in,
  output logic                     busy,
  output logic                     sched_valid,
  output logic                     sched_none,
  output logic [$clog2(NPROC)-1:0] next_id,
  output logic [PCW-1:0]           next_pc,
  output logic                     cmd_err,
  output logic [$clog2(NPROC):0]   num_active
);

  localparam int IDW = $clog2(NPROC);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NPROC - 1);

  slot_state_t    slot_state [NPROC];
  logic [PCW-1:0] slot_pc    [NPROC];

  logic [NPROC-1:0] create_vec;
  logic [NPROC-1:0] save_vec;
  logic [NPROC-1:0] finish_vec;
  logic [NPROC-1:0] select_vec;

  fsm_state_t     state;
  logic [IDW-1:0] scan_ptr;
  logic [IDW-1:0] scan_cnt;
  logic [IDW-1:0] last_sel;
  logic           found;

  slot_state_t tgt_state;
  logic        do_create;
  logic        do_save;
  logic        do_finish;
  logic        do_sched;
  logic        reject;
  logic        hit;

  // Only the highest-priority request is considered; every lower one is
  // dropped and flagged, even when the winner itself is accepted.
  always_comb begin
    tgt_state = slot_state[proc_id];
    do_create = 1'b0;
    do_save   = 1'b0;
    do_finish = 1'b0;
    do_sched  = 1'b0;
    reject    = 1'b0;
    if (state != ST_IDLE) begin
      reject = finish_req | save_req | create_req | sched_req;
    end else if (finish_req) begin
      do_finish = (tgt_state != SLOT_FREE);
      reject    = !do_finish | save_req | create_req | sched_req;
    end else if (save_req) begin
      do_save = (tgt_state == SLOT_RUNNING);
      reject  = !do_save | create_req | sched_req;
    end else if (create_req) begin
      do_create = (tgt_state == SLOT_FREE);
      reject    = !do_create | sched_req;
    end else begin
      do_sched = sched_req;
    end
    hit = (state == ST_SCAN) && (slot_state[scan_ptr] == SLOT_READY);
  end

  generate
    for (genvar gi = 0; gi < NPROC; gi++) begin : g_slot
      assign create_vec[gi] = do_create && (proc_id == IDW'(gi));
      assign save_vec[gi]   = do_save   && (proc_id == IDW'(gi));
      assign finish_vec[gi] = do_finish && (proc_id == IDW'(gi));
      assign select_vec[gi] = hit       && (scan_ptr == IDW'(gi));

      context_slot #(.PCW(PCW)) u_slot (
        .clk    (clk),
        .reset  (reset),
        .create (create_vec[gi]),
        .save   (save_vec[gi]),
        .finish (finish_vec[gi]),
        .select (select_vec[gi]),
        .pc_in  (pc_in),
        .state  (slot_state[gi]),
        .pc     (slot_pc[gi])
      );
    end
  endgenerate

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      scan_ptr    <= '0;
      scan_cnt    <= '0;
      last_sel    <= LAST_ID;
      found       <= 1'b0;
      next_id     <= '0;
      next_pc     <= '0;
      sched_valid <= 1'b0;
      sched_none  <= 1'b0;
    end else begin
      sched_valid <= 1'b0;
      sched_none  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (do_sched) begin
            scan_ptr <= last_sel + 1'b1;
            scan_cnt <= '0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            found    <= 1'b1;
            last_sel <= scan_ptr;
            next_id  <= scan_ptr;
            next_pc  <= slot_pc[scan_ptr];
            state    <= ST_REPORT;
          end else begin
            found    <= 1'b0;
            scan_ptr <= scan_ptr + 1'b1;
            scan_cnt <= scan_cnt + 1'b1;
            // The last of NPROC candidates just missed.
            if (scan_cnt == LAST_ID) state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          sched_valid <= found;
          sched_none  <= !found;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_err    <= 1'b0;
      num_active <= '0;
    end else begin
      cmd_err <= reject;
      if (do_create)      num_active <= num_active + 1'b1;
      else if (do_finish) num_active <= num_active - 1'b1;
    end
  end

endmodule

// File: tb/tb_process_ready_table.sv
// Directed bench: command vector table plus hand-written scheduling sequences.
module tb_process_ready_table;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        create_req = 1'b0;
  logic        save_req = 1'b0;
  logic        finish_req = 1'b0;
  logic        sched_req = 1'b0;
  logic [2:0]  proc_id = 3'd0;
  logic [31:0] pc_in = 32'd0;
  logic        busy;
  logic        sched_valid;
  logic        sched_none;
  logic [2:0]  next_id;
  logic [31:0] next_pc;
  logic        cmd_err;
  logic [3:0]  num_active;

  int checks = 0;
  int errors = 0;

  process_ready_table #(.NPROC(8), .PCW(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .create_req  (create_req),
    .save_req    (save_req),
    .finish_req  (finish_req),
    .sched_req   (sched_req),
    .proc_id     (proc_id),
    .pc_in       (pc_in),
    .busy        (busy),
    .sched_valid (sched_valid),
    .sched_none  (sched_none),
    .next_id     (next_id),
    .next_pc     (next_pc),
    .cmd_err     (cmd_err),
    .num_active  (num_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr;
    logic        sv;
    logic        fn;
    logic        sc;
    logic [2:0]  id;
    logic [31:0] pc;
    logic        err;
    logic [3:0]  num;
    logic        bsy;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    create_req = 1'b0;
    save_req   = 1'b0;
    finish_req = 1'b0;
    sched_req  = 1'b0;
  endtask

  task automatic step(input logic cr, input logic sv, input logic fn, input logic sc,
                      input logic [2:0] id, input logic [31:0] pc);
    @(negedge clk);
    create_req = cr;
    save_req   = sv;
    finish_req = fn;
    sched_req  = sc;
    proc_id    = id;
    pc_in      = pc;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int i);
    step(vecs[i].cr, vecs[i].sv, vecs[i].fn, vecs[i].sc, vecs[i].id, vecs[i].pc);
    $display("vec %0d: cr=%0b sv=%0b fn=%0b sc=%0b id=%0d pc=0x%0h -> err=%0b num=%0d busy=%0b",
             i, vecs[i].cr, vecs[i].sv, vecs[i].fn, vecs[i].sc, vecs[i].id, vecs[i].pc,
             cmd_err, num_active, busy);
    check($sformatf("vec%0d_cmd_err", i), 32'(cmd_err), 32'(vecs[i].err));
    check($sformatf("vec%0d_num_active", i), 32'(num_active), 32'(vecs[i].num));
    check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
  endtask

  // Issue sched_req at edge T and expect a result pulse at edge T+ecyc.
  task automatic do_sched(input string name, input logic exp_valid, input logic [2:0] eid,
                          input logic [31:0] epc, input int ecyc, input logic create_mid);
    int n;
    int busy_cnt;
    logic seen;
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    busy_cnt = busy ? 1 : 0;
    n = 0;
    seen = 1'b0;
    if (create_mid) begin
      create_req = 1'b1;
      proc_id    = 3'd6;
      pc_in      = 32'h66;
    end
    while (n < 20 && !seen) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && create_mid) begin
        clear_inputs();
        check({name, "_busy_create_err"}, 32'(cmd_err), 32'd1);
      end
      if (sched_valid || sched_none) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    $display("sched %s: after %0d cycles valid=%0b none=%0b id=%0d pc=0x%0h busy_cycles=%0d",
             name, n, sched_valid, sched_none, next_id, next_pc, busy_cnt);
    check({name, "_latency"}, 32'(n), 32'(ecyc));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(ecyc));
    check({name, "_valid"}, 32'(sched_valid), 32'(exp_valid));
    check({name, "_none"}, 32'(sched_none), 32'(!exp_valid));
    check({name, "_next_id"}, 32'(next_id), 32'(eid));
    check({name, "_next_pc"}, next_pc, epc);
    @(posedge clk);
    #1;
    check({name, "_pulse_end"}, 32'({sched_valid, sched_none}), 32'd0);
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h40, 1'b0, 4'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h10, 1'b0, 4'd1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h20, 1'b0, 4'd2, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h15, 1'b0, 4'd2, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'h30, 1'b0, 4'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 32'h31, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h32, 1'b1, 4'd2, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 32'h50, 1'b0, 4'd3, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 32'h99, 1'b1, 4'd3, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 32'h0,  1'b1, 4'd3, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 32'h70, 1'b0, 4'd4, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 32'h71, 1'b1, 4'd4, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'hA0, 1'b0, 4'd4, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h0,  1'b0, 4'd3, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 32'h44, 1'b1, 4'd4, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 32'h33, 1'b1, 4'd4, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 32'h66, 1'b0, 4'd1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h70, 1'b0, 4'd1, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 32'h77, 1'b0, 4'd2, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sched_valid", 32'(sched_valid), 32'd0);
    check("reset_sched_none", 32'(sched_none), 32'd0);
    check("reset_next_id", 32'(next_id), 32'd0);
    check("reset_next_pc", next_pc, 32'd0);
    check("reset_cmd_err", 32'(cmd_err), 32'd0);
    check("reset_num_active", 32'(num_active), 32'd0);

    // Empty table: full wrap with no hit.
    do_sched("empty", 1'b0, 3'd0, 32'h0, 9, 1'b0);

    run_vec(0);
    do_sched("single_id3", 1'b1, 3'd3, 32'h40, 5, 1'b0);

    do_reset();
    run_vec(1);
    run_vec(2);
    do_sched("rr_id0", 1'b1, 3'd0, 32'h10, 2, 1'b0);
    run_vec(3);
    do_sched("rr_id1", 1'b1, 3'd1, 32'h20, 2, 1'b0);
    do_sched("rr_id0_saved", 1'b1, 3'd0, 32'h15, 8, 1'b0);
    run_vec(4);
    do_sched("run_id2", 1'b1, 3'd2, 32'h30, 3, 1'b0);
    for (int i = 5; i <= 8; i++) run_vec(i);
    do_sched("id5_pc_kept", 1'b1, 3'd5, 32'h50, 4, 1'b0);
    do_sched("busy_create", 1'b0, 3'd5, 32'h50, 9, 1'b1);
    for (int i = 9; i <= 15; i++) run_vec(i);
    do_sched("skip_to_id7", 1'b1, 3'd7, 32'h70, 3, 1'b0);

    // Reset in the middle of a scan.
    do_reset();
    run_vec(16);
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midscan_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (sched_valid || sched_none) pulses++;
    end
    $display("midscan reset: pulses=%0d busy=%0b num=%0d", pulses, busy, num_active);
    check("midscan_no_pulse", 32'(pulses), 32'd0);
    check("midscan_num_active", 32'(num_active), 32'd0);
    run_vec(17);
    run_vec(18);
    do_sched("post_reset_slot0", 1'b1, 3'd0, 32'h70, 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
